// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - parity encodings as they appear on cfg_parity
//   - transmitter FSM state enum
//   - reset/default divisor and the minimum divisor applied to cfg_divisor
//   - frame_parity(): parity bit for a given byte / data width / parity mode
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DEFAULT_DIV = 1085;   // 125 MHz / 115200 baud
   localparam int MIN_DIV     = 2;      // smaller divisors are clamped to this

   // cfg_parity encoding; 2'b11 is not listed and behaves as none
   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK,
      ST_MARK      // one mark symbol after a break is released
   } tx_state_t;

   // Parity over the transmitted data bits only (5..8 of them).
   function automatic logic frame_parity(input logic [7:0] data,
                                         input logic [1:0] data_bits,
                                         input logic [1:0] parity);
      logic [7:0] mask;
      mask = 8'hFF >> (2'd3 - data_bits);
      return (^(data & mask)) ^ (parity == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO buffering bytes between the register interface and the
// transmitter FSM. Writes are dropped when full, reads ignored when empty.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   wr_data      data to push          wr_en   push request
//   rd_data      head of FIFO          rd_en   pop request
//   full, empty  status               count   entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 8,     // power of two, >= 2
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // power-of-two depth: pointers wrap by natural overflow
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; validity is defined solely by
   // the pointers and count, and a resettable array would not map to RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_configurable.sv
// -----------------------------------------------------------------------------
// uart_tx_configurable
// Run-time configurable UART transmitter fed from an input FIFO.
// Frame: start, 5..8 data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. Config is latched when a frame is loaded. A line break
// can be requested from IDLE; releasing it sends one mark symbol.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cfg_divisor      clk cycles per symbol (values < 2 act as 2)
//   cfg_data_bits    data bits - 5
//   cfg_parity       00 none, 01 even, 10 odd, 11 none
//   cfg_stop2        1 = two stop bits
//   send_break       hold the line low while high (sampled in IDLE)
//   data_in / data_in_valid / data_in_ready   byte push handshake
//   serial_out       registered TX line, idle high
//   tx_busy          frame/break active or FIFO non-empty
//   fifo_count       entries held in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_configurable #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIV_WIDTH-1:0]          cfg_divisor,
   input  logic [1:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic                          send_break,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   import uart_pkg::*;

   tx_state_t            state, state_n;
   logic                 out_n;
   logic                 load;        // pop FIFO and latch frame config
   logic                 mark_load;   // break released: time one mark symbol
   logic                 sym_end;
   logic [DIV_WIDTH-1:0] div_m1;      // clamped divisor minus one
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] sym_cnt;
   logic [2:0]           bit_cnt;     // data bit index, then stop symbol index
   logic [2:0]           last_q;      // index of last data bit (4..7)
   logic [7:0]           shifter;
   logic                 par_en_q;
   logic                 par_bit_q;
   logic                 stop2_q;
   logic [7:0]           fifo_data;
   logic                 fifo_full;
   logic                 fifo_empty;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_data (data_in),
      .wr_en   (data_in_valid),
      .rd_en   (load),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign data_in_ready = !fifo_full;
   assign tx_busy       = (state != ST_IDLE) || !fifo_empty;
   assign sym_end       = (sym_cnt == '0);
   assign div_m1        = (cfg_divisor < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV - 1)
                                                              : cfg_divisor - DIV_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         serial_out <= 1'b1;
      end else begin
         state      <= state_n;
         serial_out <= out_n;
      end
   end

   // NOTE: every signal assigned below gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_n   = state;
      out_n     = serial_out;
      load      = 1'b0;
      mark_load = 1'b0;
      case (state)
         ST_IDLE: begin
            out_n = 1'b1;
            if (send_break) begin
               state_n = ST_BREAK;
               out_n   = 1'b0;
            end else if (!fifo_empty) begin
               state_n = ST_START;
               out_n   = 1'b0;
               load    = 1'b1;
            end
         end
         ST_START: if (sym_end) begin
            state_n = ST_DATA;
            out_n   = shifter[0];
         end
         ST_DATA: if (sym_end) begin
            if (bit_cnt != last_q) begin
               out_n = shifter[1];          // shifter moves one place this edge
            end else if (par_en_q) begin
               state_n = ST_PARITY;
               out_n   = par_bit_q;
            end else begin
               state_n = ST_STOP;
               out_n   = 1'b1;
            end
         end
         ST_PARITY: if (sym_end) begin
            state_n = ST_STOP;
            out_n   = 1'b1;
         end
         ST_STOP: if (sym_end && !(stop2_q && bit_cnt == 3'd0)) begin
            // back-to-back frames: start immediately, no idle cycle
            if (!fifo_empty) begin
               state_n = ST_START;
               out_n   = 1'b0;
               load    = 1'b1;
            end else begin
               state_n = ST_IDLE;
               out_n   = 1'b1;
            end
         end
         ST_BREAK: begin
            out_n = 1'b0;
            if (!send_break) begin
               state_n   = ST_MARK;
               out_n     = 1'b1;
               mark_load = 1'b1;
            end
         end
         ST_MARK: if (sym_end) begin
            state_n = ST_IDLE;
            out_n   = 1'b1;
         end
         default: begin
            state_n = ST_IDLE;
            out_n   = 1'b1;
         end
      endcase
   end

   // Symbol timing and frame datapath. The symbol counter free-runs outside
   // timed states; it is reloaded whenever a frame or mark symbol begins.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         sym_cnt   <= '0;
         bit_cnt   <= '0;
         last_q    <= '0;
         shifter   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
      end else if (load) begin
         div_q     <= div_m1;
         sym_cnt   <= div_m1;
         bit_cnt   <= '0;
         last_q    <= {1'b1, cfg_data_bits};
         shifter   <= fifo_data;
         par_en_q  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
         par_bit_q <= frame_parity(fifo_data, cfg_data_bits, cfg_parity);
         stop2_q   <= cfg_stop2;
      end else if (mark_load) begin
         div_q   <= div_m1;
         sym_cnt <= div_m1;
      end else if (sym_end) begin
         sym_cnt <= div_q;
         if (state == ST_DATA) begin
            shifter <= shifter >> 1;
            bit_cnt <= (bit_cnt == last_q) ? 3'd0 : bit_cnt + 3'd1;
         end else if (state == ST_STOP) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
      end else begin
         sym_cnt <= sym_cnt - DIV_WIDTH'(1);
      end
   end

endmodule
